fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch unit: the program-counter side of the control decoder's interface.
- Holds the PC, drives the instruction-ROM address and sequences execution through idle, run and halt.
- Applies the decoder's branch/halt outputs together with the ALU compare flag.
- Branch targets come from an internal lookup table (LUT), because the 9-bit ISA cannot encode full addresses; the LUT is loaded before program start.

Parameters:
PC_W, 10, PC / instruction-ROM address width
LUT_AW, 5, LUT index width (2^LUT_AW entries, each PC_W bits)
CNT_W, 16, cycle counter width

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  begin program execution from PC 0
Stall  input  1  hold PC for this cycle
Halt  input  1  decoder: current instruction is halt
Branch_en  input  1  decoder: current instruction is a branch
Branch_taken  input  1  ALU compare flag (condition true)
Branch_rel  input  1  1 = PC-relative target, 0 = absolute target
Target_index  input  LUT_AW  LUT entry selected by the branch
Lut_we  input  1  LUT write enable
Lut_waddr  input  LUT_AW  LUT write index
Lut_wdata  input  PC_W  LUT write data
Instr_addr  output  PC_W  registered PC, drives the instruction ROM
Instr_valid  output  1  1 while in RUN
Done  output  1  1 while in HALTED
Cycle_count  output  CNT_W  cycles spent in RUN since last Start

Behaviour:
- Reset, synchronous and active-high: state=IDLE, Instr_addr=0, Instr_valid=0, Done=0, Cycle_count=0, all LUT entries=0. Reset asserted mid-run aborts immediately to IDLE.
- Outputs are registered. The ROM is combinational, so the instruction at Instr_addr reaches the decoder in the same cycle, and the decoder outputs act on the next edge.
- IDLE:
  - Instr_addr=0, Instr_valid=0, Done=0.
  - Start=1 -> RUN next cycle; PC=0, Cycle_count=0.
- RUN:
  - Instr_valid=1.
  - Cycle_count increments every RUN cycle, including stalled cycles, and saturates at all-ones.
  - Start is ignored.
  - Per-edge priority, highest first:
    1. Stall=1: PC held; Halt and branch inputs ignored.
    2. Halt=1: PC held; -> HALTED.
    3. Branch_en=1 and Branch_taken=1, Branch_rel=0: PC <= LUT[Target_index].
    4. Branch_en=1 and Branch_taken=1, Branch_rel=1: PC <= PC + LUT[Target_index], modulo 2^PC_W; a LUT entry used relatively is two's complement.
    5. Otherwise, including Branch_en=1 with Branch_taken=0: PC <= PC+1, modulo 2^PC_W. PC wraps from all-ones to 0 with no error.
- HALTED:
  - Done=1, Instr_valid=0; Instr_addr and Cycle_count hold their final values.
  - Start=1 -> RUN next cycle; PC=0, Cycle_count=0, Done=0.
- LUT:
  - Write at edge when Lut_we=1; allowed in any state.
  - A read of the same index in the same cycle returns the old value; the new value is visible from the next cycle.
- Inputs other than Start, Reset and the Lut_* signals are don't-care outside RUN.

Test Plan:
- Reset, then Start pulse, 5 cycles with no control inputs -> Instr_addr sequence 0,1,2,3,4; Instr_valid=1; Cycle_count=5.
- LUT[3]=40; at PC=7 Branch_en=1, Branch_taken=1, Branch_rel=0, Target_index=3 -> next Instr_addr=40. Repeat with Branch_taken=0 -> next Instr_addr=8.
- LUT[1]=0x3FC (-4); at PC=10 relative taken branch -> 6. LUT[2]=5; at PC=0x3FE relative taken branch -> 3 (wrap).
- Stall=1 for 3 cycles at PC=12 with Halt=1 also asserted -> PC stays 12, state stays RUN, Cycle_count advances by 3. Stall released with Halt=1 -> Done=1, Instr_addr=12, Instr_valid=0.
- Start while HALTED -> RUN, Instr_addr=0, Cycle_count=0, Done=0. Start while RUN -> no effect.
- Reset at PC=25 in RUN -> IDLE, Instr_addr=0, LUT entries read 0. Lut_we and branch on the same index in the same cycle -> branch uses the old entry.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Program-counter side of the control decoder interface. Holds the PC that
//   addresses the (combinational) instruction ROM and sequences execution
//   through IDLE -> RUN -> HALTED. Branch targets come from an internal LUT,
//   which is written before program start because the 9-bit ISA cannot
//   encode full addresses.
//
// Parameters
//   PC_W    PC / instruction-ROM address width
//   LUT_AW  LUT index width (2**LUT_AW entries of PC_W bits)
//   CNT_W   RUN cycle counter width
//
// Ports
//   Clk           clock, all state updates on rising edge
//   Reset         synchronous active-high reset
//   Start         begin execution from PC 0 (IDLE or HALTED)
//   Stall         hold PC this cycle (highest priority in RUN)
//   Halt          decoder: current instruction is halt
//   Branch_en     decoder: current instruction is a branch
//   Branch_taken  ALU compare flag
//   Branch_rel    1 = PC-relative target, 0 = absolute target
//   Target_index  LUT entry selected by the branch
//   Lut_we        LUT write enable
//   Lut_waddr     LUT write index
//   Lut_wdata     LUT write data
//   Instr_addr    registered PC, drives the instruction ROM
//   Instr_valid   1 while in RUN
//   Done          1 while in HALTED
//   Cycle_count   RUN cycles since last Start, saturating
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int PC_W   = 10,
   parameter int LUT_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Stall,
   input  logic              Halt,
   input  logic              Branch_en,
   input  logic              Branch_taken,
   input  logic              Branch_rel,
   input  logic [LUT_AW-1:0] Target_index,
   input  logic              Lut_we,
   input  logic [LUT_AW-1:0] Lut_waddr,
   input  logic [PC_W-1:0]   Lut_wdata,
   output logic [PC_W-1:0]   Instr_addr,
   output logic              Instr_valid,
   output logic              Done,
   output logic [CNT_W-1:0]  Cycle_count
);

   localparam int LUT_N = 1 << LUT_AW;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALTED  = 2'd2
   } state_t;

   state_t                  r_state;
   logic [PC_W-1:0]         r_pc;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_valid;
   logic                    r_done;
   logic [PC_W-1:0]         r_lut [LUT_N];

   logic [PC_W-1:0]         w_lut_rd;
   logic signed [PC_W-1:0]  w_off;
   logic signed [PC_W-1:0]  w_pc_s;
   logic signed [PC_W-1:0]  w_rel_sum;
   logic [PC_W-1:0]         w_rel_tgt;
   logic [PC_W-1:0]         w_pc_inc;

   // Counter holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Asynchronous read: a write to the same index this cycle is seen next cycle.
   assign w_lut_rd  = r_lut[Target_index];

   // Relative entries are two's complement; the sum wraps modulo 2**PC_W.
   assign w_off     = $signed(w_lut_rd);
   assign w_pc_s    = $signed(r_pc);
   assign w_rel_sum = w_pc_s + w_off;
   assign w_rel_tgt = $unsigned(w_rel_sum);
   assign w_pc_inc  = r_pc + PC_W'(1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < LUT_N; i++) begin
            r_lut[i] <= '0;
         end
      end else if (Lut_we) begin
         r_lut[Lut_waddr] <= Lut_wdata;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_HALTED: begin
               // HALTED keeps the final PC and count until the next Start.
               if (Start) begin
                  r_state <= S_RUN;
                  r_pc    <= '0;
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            S_RUN: begin
               // Stalled cycles still count as RUN cycles.
               r_cnt <= sat_inc(r_cnt);
               if (!Stall) begin
                  if (Halt) begin
                     r_state <= S_HALTED;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (Branch_en && Branch_taken) begin
                     r_pc <= Branch_rel ? w_rel_tgt : w_lut_rd;
                  end else begin
                     r_pc <= w_pc_inc;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_pc    <= '0;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign Instr_addr  = r_pc;
   assign Instr_valid = r_valid;
   assign Done        = r_done;
   assign Cycle_count = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam int PC_W   = 10;
   localparam int LUT_AW = 5;
   localparam int CNT_W  = 16;
   localparam int SAT_W  = 3;

   logic              Clk = 1'b0;
   logic              Reset, Start, Stall, Halt;
   logic              Branch_en, Branch_taken, Branch_rel;
   logic [LUT_AW-1:0] Target_index;
   logic              Lut_we;
   logic [LUT_AW-1:0] Lut_waddr;
   logic [PC_W-1:0]   Lut_wdata;
   logic [PC_W-1:0]   Instr_addr;
   logic              Instr_valid, Done;
   logic [CNT_W-1:0]  Cycle_count;
   logic [PC_W-1:0]   s_addr;
   logic              s_vld, s_done;
   logic [SAT_W-1:0]  s_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 Clk = ~Clk;

   fetch_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
      .Branch_en(Branch_en), .Branch_taken(Branch_taken), .Branch_rel(Branch_rel),
      .Target_index(Target_index), .Lut_we(Lut_we), .Lut_waddr(Lut_waddr),
      .Lut_wdata(Lut_wdata), .Instr_addr(Instr_addr), .Instr_valid(Instr_valid),
      .Done(Done), .Cycle_count(Cycle_count)
   );

   // Narrow-counter copy driven identically, to reach saturation quickly.
   fetch_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(SAT_W)) dut_s (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
      .Branch_en(Branch_en), .Branch_taken(Branch_taken), .Branch_rel(Branch_rel),
      .Target_index(Target_index), .Lut_we(Lut_we), .Lut_waddr(Lut_waddr),
      .Lut_wdata(Lut_wdata), .Instr_addr(s_addr), .Instr_valid(s_vld),
      .Done(s_done), .Cycle_count(s_cnt)
   );

   typedef struct {
      logic [5:0]        ctl;   // {start, stall, halt, ben, btaken, brel}
      logic [LUT_AW-1:0] tidx;
      logic              we;
      logic [LUT_AW-1:0] wa;
      logic [PC_W-1:0]   wd;
      logic [PC_W-1:0]   e_addr;
      logic              e_vld;
      logic              e_done;
      logic [CNT_W-1:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_START = 6'b100000;
   localparam logic [5:0] C_SH    = 6'b011000;
   localparam logic [5:0] C_HALT  = 6'b001000;
   localparam logic [5:0] C_ABS   = 6'b000110;
   localparam logic [5:0] C_REL   = 6'b000111;
   localparam logic [5:0] C_NTKN  = 6'b000100;

   function automatic vec_t mk(input logic [5:0] ctl, input int tidx, input logic we,
                               input int wa, input int wd, input int ea,
                               input logic ev, input logic ed, input int ec);
      vec_t v;
      v.ctl    = ctl;
      v.tidx   = LUT_AW'(tidx);
      v.we     = we;
      v.wa     = LUT_AW'(wa);
      v.wd     = PC_W'(wd);
      v.e_addr = PC_W'(ea);
      v.e_vld  = ev;
      v.e_done = ed;
      v.e_cnt  = CNT_W'(ec);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      {Start, Stall, Halt, Branch_en, Branch_taken, Branch_rel} = v.ctl;
      Target_index = v.tidx;
      Lut_we       = v.we;
      Lut_waddr    = v.wa;
      Lut_wdata    = v.wd;
   endtask

   task automatic step(input vec_t v, input string tag);
      int sat;
      drive(v);
      @(posedge Clk);
      #1;
      sat = (v.e_cnt > 7) ? 7 : int'(v.e_cnt);
      chk({tag, "_addr"},  32'(Instr_addr),  32'(v.e_addr));
      chk({tag, "_valid"}, 32'(Instr_valid), 32'(v.e_vld));
      chk({tag, "_done"},  32'(Done),        32'(v.e_done));
      chk({tag, "_cnt"},   32'(Cycle_count), 32'(v.e_cnt));
      chk({tag, "_satcnt"}, 32'(s_cnt),      32'(sat));
   endtask

   initial begin
      Reset = 1'b1;
      drive(mk(C_NONE, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_addr",  32'(Instr_addr),  32'd0);
      chk("rst_valid", 32'(Instr_valid), 32'd0);
      chk("rst_done",  32'(Done),        32'd0);
      chk("rst_cnt",   32'(Cycle_count), 32'd0);
      Reset = 1'b0;

      // LUT setup in IDLE
      tbl.push_back(mk(C_NONE,  0, 1, 3, 40,    0, 0, 0, 0));
      tbl.push_back(mk(C_NONE,  0, 1, 1, 'h3FC, 0, 0, 0, 0));
      tbl.push_back(mk(C_NONE,  0, 1, 2, 5,     0, 0, 0, 0));
      tbl.push_back(mk(C_NONE,  0, 1, 4, 7,     0, 0, 0, 0));
      tbl.push_back(mk(C_NONE,  0, 1, 5, 10,    0, 0, 0, 0));
      tbl.push_back(mk(C_NONE,  0, 1, 6, 'h3FE, 0, 0, 0, 0));
      tbl.push_back(mk(C_NONE,  0, 1, 7, 12,    0, 0, 0, 0));
      tbl.push_back(mk(C_NONE,  0, 1, 8, 25,    0, 0, 0, 0));
      // Start and sequential fetch
      tbl.push_back(mk(C_START, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int k = 1; k <= 7; k++) tbl.push_back(mk(C_NONE, 0, 0, 0, 0, k, 1, 0, k));
      // Branches
      tbl.push_back(mk(C_ABS,  3, 0, 0, 0, 40,    1, 0, 8));
      tbl.push_back(mk(C_ABS,  4, 0, 0, 0, 7,     1, 0, 9));
      tbl.push_back(mk(C_NTKN, 3, 0, 0, 0, 8,     1, 0, 10));
      tbl.push_back(mk(C_ABS,  5, 0, 0, 0, 10,    1, 0, 11));
      tbl.push_back(mk(C_REL,  1, 0, 0, 0, 6,     1, 0, 12));
      tbl.push_back(mk(C_ABS,  6, 0, 0, 0, 'h3FE, 1, 0, 13));
      tbl.push_back(mk(C_REL,  2, 0, 0, 0, 3,     1, 0, 14));
      tbl.push_back(mk(C_NONE, 0, 0, 0, 0, 4,     1, 0, 15));
      // PC wrap from all-ones
      tbl.push_back(mk(C_ABS,  6, 0, 0, 0, 'h3FE, 1, 0, 16));
      tbl.push_back(mk(C_NONE, 0, 0, 0, 0, 'h3FF, 1, 0, 17));
      tbl.push_back(mk(C_NONE, 0, 0, 0, 0, 0,     1, 0, 18));
      // Start while RUN is ignored
      tbl.push_back(mk(C_START, 0, 0, 0, 0, 1,    1, 0, 19));
      // Stall outranks Halt, then Halt
      tbl.push_back(mk(C_ABS,  7, 0, 0, 0, 12,    1, 0, 20));
      tbl.push_back(mk(C_SH,   0, 0, 0, 0, 12,    1, 0, 21));
      tbl.push_back(mk(C_SH,   0, 0, 0, 0, 12,    1, 0, 22));
      tbl.push_back(mk(C_SH,   0, 0, 0, 0, 12,    1, 0, 23));
      tbl.push_back(mk(C_HALT, 0, 0, 0, 0, 12,    0, 1, 24));
      tbl.push_back(mk(C_ABS,  3, 0, 0, 0, 12,    0, 1, 24));
      // Restart from HALTED
      tbl.push_back(mk(C_START, 0, 0, 0, 0, 0,    1, 0, 0));

      foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

      // Reset mid-run aborts to IDLE and clears the LUT
      step(mk(C_ABS, 8, 0, 0, 0, 25, 1, 0, 1), "to25");
      Reset = 1'b1;
      step(mk(C_NONE, 0, 0, 0, 0, 0, 0, 0, 0), "midrst");
      Reset = 1'b0;
      step(mk(C_START, 0, 0, 0, 0, 0, 1, 0, 0), "rst_start");
      step(mk(C_ABS,   3, 0, 0, 0, 0, 1, 0, 1), "lut3_clr");
      step(mk(C_REL,   1, 0, 0, 0, 0, 1, 0, 2), "lut1_clr");
      // Same-cycle write and branch on one index uses the old entry
      step(mk(C_ABS,   3, 1, 3, 50, 0, 1, 0, 3), "wr_old");
      step(mk(C_ABS,   3, 0, 0, 0, 50, 1, 0, 4), "wr_new");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
